osc_reset_sequencer: RTL
========================

OSC_RESET_SEQUENCER -- requirements
Module: osc_reset_sequencer

Interface
REQ-001: Parameter STARTUP_CYCLES, default 1024: oscillator settle time before the PLL is touched.
REQ-002: Parameter PLL_RST_CYCLES, default 16: CCC PLL reset pulse width.
REQ-003: Parameter LOCK_FILTER, default 16: consecutive synchronized lock-high samples required.
REQ-004: Parameter LOCK_TIMEOUT, default 65535: WAIT_LOCK cycle limit per attempt.
REQ-005: Parameter STAGGER_CYCLES, default 8: gap between successive reset releases.
REQ-006: Parameter MAX_RETRIES, default 3: lock timeouts tolerated before FAULT.
REQ-007: clk  in  1  RC oscillator 25/50 MHz fabric clock; the only clock.
REQ-008: reset  in  1  synchronous, active-high reset.
REQ-009: pll_lock  in  1  CCC PLL lock, asynchronous to clk.
REQ-010: mss_ready  in  1  MSS reset-done, synchronous to clk.
REQ-011: retry_req  in  1  single-cycle pulse; restarts the sequence from FAULT.
REQ-012: ccc_reset  out  1  active-high reset to the CCC/PLL.
REQ-013: fabric_reset  out  1  active-high fabric core reset.
REQ-014: periph_reset  out  1  active-high fabric peripheral reset.
REQ-015: ready  out  1  high only in RUN.
REQ-016: lock_fail  out  1  high only in FAULT.
REQ-017: state  out  3  current state encoding.
REQ-018: retry_count  out  4  lock timeouts in the current attempt series, saturating at 15.

Function
REQ-019: All outputs SHALL be registered; no combinational path from any input to any output.
REQ-020: pll_lock SHALL pass through a 2-flop synchronizer (lock_s); FSM decisions use lock_s only.
REQ-021: A single 16-bit cycle counter SHALL clear on every state change; all parameters SHALL be in the range 1..65535.
REQ-022: States and encodings SHALL be: WAIT_OSC=0, PLL_RST=1, WAIT_LOCK=2, WAIT_MSS=3, REL_FAB=4, REL_PERIPH=5, RUN=6, FAULT=7.
REQ-023: WAIT_OSC SHALL last exactly STARTUP_CYCLES cycles, then go to PLL_RST; ccc_reset, fabric_reset and periph_reset = 1.
REQ-024: PLL_RST SHALL last exactly PLL_RST_CYCLES cycles with ccc_reset=1, then go to WAIT_LOCK.
REQ-025: WAIT_LOCK: ccc_reset=0; a filter counter increments while lock_s=1 and clears when lock_s=0; on reaching LOCK_FILTER, go to WAIT_MSS.
REQ-026: WAIT_LOCK timeout: after LOCK_TIMEOUT cycles without a filter pass, increment retry_count; go to PLL_RST if the new value < MAX_RETRIES, else go to FAULT.
REQ-027: If the filter pass and the timeout occur in the same cycle, the filter pass SHALL win.
REQ-028: WAIT_MSS: stay until mss_ready=1, then go to REL_FAB; no timeout.
REQ-029: REL_FAB: fabric_reset=0 from the first cycle; after STAGGER_CYCLES cycles go to REL_PERIPH.
REQ-030: REL_PERIPH: periph_reset=0 as well; after STAGGER_CYCLES cycles go to RUN.
REQ-031: RUN: ready=1, all resets 0, and retry_count clears to 0 on entry.
REQ-032: Lock loss: lock_s=0 in WAIT_MSS, REL_FAB, REL_PERIPH or RUN SHALL go to PLL_RST next cycle.
REQ-033: On lock loss, fabric_reset=1, periph_reset=1, ready=0 and ccc_reset=1 SHALL be registered on that same transition; retry_count is unchanged.
REQ-034: FAULT: all resets 1, lock_fail=1, ready=0; retry_req=1 SHALL go to PLL_RST with retry_count cleared and lock_fail=0 the next cycle.
REQ-035: retry_req SHALL be ignored outside FAULT.
REQ-036: Output invariant: periph_reset=0 implies fabric_reset=0, and fabric_reset=0 implies ccc_reset=0.

Reset
REQ-037: reset=1 SHALL force the following on the next clk edge, from any state including mid-count: state=WAIT_OSC, counters=0, retry_count=0, synchronizer flops=0, ccc_reset=fabric_reset=periph_reset=1, ready=0, lock_fail=0.
REQ-038: reset SHALL take priority over every other input in the same cycle.

Verification
Parameters for all scenarios: STARTUP=8, PLL_RST=4, FILTER=4, TIMEOUT=32, STAGGER=2, MAX_RETRIES=2.
REQ-039: Nominal: pll_lock=1 and mss_ready=1 constant -> ccc_reset falls at cycle 12 after reset release, fabric_reset at 19, periph_reset at 21, ready at 23.
REQ-040: Lock glitch: lock_s drops after 3 high samples in WAIT_LOCK -> filter restarts; WAIT_MSS is entered only after 4 consecutive high samples.
REQ-041: Timeouts: pll_lock=0 constant -> PLL_RST re-entered once with retry_count=1, then FAULT with lock_fail=1 and retry_count=2.
REQ-042: FAULT recovery: retry_req pulse in FAULT -> state=1, lock_fail=0, retry_count=0 next cycle; a retry_req pulse in RUN has no effect.
REQ-043: Lock loss in RUN: pll_lock=0 -> after 2 sync cycles plus 1, ready=0 and all resets=1 together; the sequence then re-runs to RUN.
REQ-044: reset asserted mid-REL_PERIPH -> state=0 and all resets=1 next cycle, and the full nominal timing repeats.

Source files
------------

// File: rtl/osc_reset_sequencer.sv
// ---------------------------------------------------------------------------
// osc_reset_sequencer
//
// Power-up reset sequencer for an RC-oscillator clocked fabric. It lets the
// oscillator settle, pulses the CCC/PLL reset, waits for a filtered PLL lock
// and then for the MSS, and finally releases the fabric core reset and the
// fabric peripheral reset in a staggered order. Lock timeouts are retried a
// limited number of times before parking in FAULT. Losing lock after the
// PLL has been accepted restarts the sequence from the PLL reset.
//
// Ports
//   clk          : fabric clock, the only clock
//   reset        : synchronous active-high reset
//   pll_lock     : CCC PLL lock, asynchronous to clk
//   mss_ready    : MSS reset-done, synchronous to clk
//   retry_req    : single-cycle pulse, restarts the sequence from FAULT
//   ccc_reset    : active-high reset to the CCC/PLL
//   fabric_reset : active-high fabric core reset
//   periph_reset : active-high fabric peripheral reset
//   ready        : high only in RUN
//   lock_fail    : high only in FAULT
//   state        : current FSM state (debug/observation)
//   retry_count  : lock timeouts in the current attempt series, saturating
//
// All outputs come straight from flops; the output flops are loaded from
// the next-state decode so they change on the same edge as the state.
// ---------------------------------------------------------------------------
module osc_reset_sequencer #(
   parameter int STARTUP_CYCLES = 1024,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_FILTER    = 16,
   parameter int LOCK_TIMEOUT   = 65535,
   parameter int STAGGER_CYCLES = 8,
   parameter int MAX_RETRIES    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_lock,
   input  logic       mss_ready,
   input  logic       retry_req,
   output logic       ccc_reset,
   output logic       fabric_reset,
   output logic       periph_reset,
   output logic       ready,
   output logic       lock_fail,
   output logic [2:0] state,
   output logic [3:0] retry_count
);

   localparam logic [15:0] P_STARTUP = 16'(STARTUP_CYCLES);
   localparam logic [15:0] P_PLL_RST = 16'(PLL_RST_CYCLES);
   localparam logic [15:0] P_FILTER  = 16'(LOCK_FILTER);
   localparam logic [15:0] P_TIMEOUT = 16'(LOCK_TIMEOUT);
   localparam logic [15:0] P_STAGGER = 16'(STAGGER_CYCLES);
   localparam logic [15:0] P_RETRIES = 16'(MAX_RETRIES);

   typedef enum logic [2:0] {
      WAIT_OSC   = 3'd0,
      PLL_RST    = 3'd1,
      WAIT_LOCK  = 3'd2,
      WAIT_MSS   = 3'd3,
      REL_FAB    = 3'd4,
      REL_PERIPH = 3'd5,
      RUN        = 3'd6,
      FAULT      = 3'd7
   } state_t;

   state_t      cur_st, nxt_st;
   logic [15:0] cnt;
   logic [15:0] filt, filt_nxt;
   logic [3:0]  retry_nxt, retry_inc;
   logic        lock_m, lock_s;
   logic        ccc_nxt, fab_nxt, per_nxt, rdy_nxt, fail_nxt;

   assign state = cur_st;

   // Two-flop synchronizer for the PLL lock. While the PLL is held in reset
   // its lock output means nothing, so the synchronizer is flushed; lock is
   // only counted from samples taken after ccc_reset has been released.
   always_ff @(posedge clk) begin
      if (reset || ccc_reset) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_lock;
         lock_s <= lock_m;
      end
   end

   always_comb begin
      nxt_st    = cur_st;
      filt_nxt  = '0;
      retry_nxt = retry_count;
      retry_inc = (retry_count == 4'hF) ? 4'hF : retry_count + 4'd1;
      case (cur_st)
         WAIT_OSC: begin
            if (cnt == P_STARTUP - 16'd1) nxt_st = PLL_RST;
         end
         PLL_RST: begin
            if (cnt == P_PLL_RST - 16'd1) nxt_st = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s) filt_nxt = filt + 16'd1;
            // Filter pass is checked first so it wins over a same-cycle timeout.
            if (lock_s && (filt == P_FILTER - 16'd1)) begin
               nxt_st = WAIT_MSS;
            end else if (cnt == P_TIMEOUT - 16'd1) begin
               retry_nxt = retry_inc;
               nxt_st    = ({12'd0, retry_inc} < P_RETRIES) ? PLL_RST : FAULT;
            end
         end
         WAIT_MSS: begin
            if (!lock_s)        nxt_st = PLL_RST;
            else if (mss_ready) nxt_st = REL_FAB;
         end
         REL_FAB: begin
            if (!lock_s)                          nxt_st = PLL_RST;
            else if (cnt == P_STAGGER - 16'd1)    nxt_st = REL_PERIPH;
         end
         REL_PERIPH: begin
            if (!lock_s)                          nxt_st = PLL_RST;
            else if (cnt == P_STAGGER - 16'd1)    nxt_st = RUN;
         end
         RUN: begin
            if (!lock_s) nxt_st = PLL_RST;
         end
         FAULT: begin
            if (retry_req) begin
               nxt_st    = PLL_RST;
               retry_nxt = 4'd0;
            end
         end
         default: nxt_st = WAIT_OSC;
      endcase
      // A successful bring-up ends the current attempt series.
      if (nxt_st == RUN && cur_st != RUN) retry_nxt = 4'd0;
      if (nxt_st != cur_st) filt_nxt = '0;

      // Output decode from the next state keeps the release order intact on
      // every edge: periph released implies fabric released implies PLL run.
      ccc_nxt  = (nxt_st == WAIT_OSC) || (nxt_st == PLL_RST) || (nxt_st == FAULT);
      fab_nxt  = !((nxt_st == REL_FAB) || (nxt_st == REL_PERIPH) || (nxt_st == RUN));
      per_nxt  = !((nxt_st == REL_PERIPH) || (nxt_st == RUN));
      rdy_nxt  = (nxt_st == RUN);
      fail_nxt = (nxt_st == FAULT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_st       <= WAIT_OSC;
         cnt          <= '0;
         filt         <= '0;
         retry_count  <= 4'd0;
         ccc_reset    <= 1'b1;
         fabric_reset <= 1'b1;
         periph_reset <= 1'b1;
         ready        <= 1'b0;
         lock_fail    <= 1'b0;
      end else begin
         cur_st <= nxt_st;
         // Single cycle counter shared by all timed states; saturates in the
         // untimed states so it never wraps back onto a terminal count.
         if (nxt_st != cur_st)  cnt <= '0;
         else if (cnt != '1)    cnt <= cnt + 16'd1;
         filt         <= filt_nxt;
         retry_count  <= retry_nxt;
         ccc_reset    <= ccc_nxt;
         fabric_reset <= fab_nxt;
         periph_reset <= per_nxt;
         ready        <= rdy_nxt;
         lock_fail    <= fail_nxt;
      end
   end

endmodule
